load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the word-addressed data memory.
//  Turns a byte-addressed RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into one memory transaction:
//  it generates the word address, byte mask and replicated write data, and for loads it extracts the
//  addressed byte/halfword from the returned word and sign- or zero-extends it.
// PARAMETERS
//  ADDR_W  12  memory word-address width; mem_address = addr[ADDR_W+1:2], upper addr bits ignored
//  XLEN    32  data/address width (only 32 supported)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       request pulse; sampled only in IDLE
//  is_store      in   1       1 = store, 0 = load
//  funct3        in   3       RV32I width/sign code
//  addr          in   XLEN    byte address
//  wdata         in   XLEN    store data, right-aligned
//  busy          out  1       high whenever state != IDLE
//  done          out  1       one-cycle completion pulse
//  rdata         out  XLEN    extended load result; valid with done, held until next done
//  err           out  1       pulses with done on illegal funct3
//  misaligned    out  1       pulses with done on misaligned access (macro only)
//  mem_request   out  1       to memory: transaction strobe, one cycle per access
//  mem_we_re     out  1       to memory: 1 = write, 0 = read
//  mem_address   out  ADDR_W  to memory: word address
//  mem_mask      out  4       to memory: byte-lane write enables
//  mem_data_in   out  XLEN    to memory: write data
//  mem_data_out  in   XLEN    from memory: read word
//  mem_valid     in   1       from memory: read data valid
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; every output listed above = 0; any in-flight access is abandoned.
//  - FSM states: IDLE, ACCESS, WAIT, DONE. All mem_* outputs are registered; none is combinational from core inputs.
//  - IDLE: start=1 latches addr/funct3/wdata/is_store and computes mask/data.
//      If the request is legal: IDLE -> ACCESS. If err (or misaligned under the macro): IDLE -> DONE with no mem_request.
//  - ACCESS: mem_request=1 for exactly one cycle.
//      Store: mem_we_re=1, then -> DONE.
//      Load: mem_we_re=0, then -> WAIT.
//  - WAIT: while mem_valid=0, stay (stall, no timeout).
//      When mem_valid=1, capture mem_data_out, extend it into rdata, -> DONE.
//  - DONE: done=1 for one cycle, then -> IDLE. err and misaligned are valid only in this cycle.
//  - Latency from start edge to done: store 2 cycles; load 3 cycles + mem_valid stall cycles.
//  - start while busy=1 is ignored (not queued).
//  - Legal funct3 values:
//      store: 000 SB, 001 SH, 010 SW.
//      load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//      Anything else sets err=1 and leaves rdata=0.
//  - Store mask and data:
//      SB: mask = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
//      SH: mask = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
//      SW: mask = 4'b1111; data = wdata.
//  - Loads drive mem_mask = 4'b0000.
//  - Load extraction:
//      byte lane = addr[1:0]; halfword lane = addr[1].
//      LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//  - Word address wrap: addresses beyond 2^ADDR_W words alias modulo (upper bits dropped).
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - A halfword with addr[0]=1 or a word with addr[1:0]!=0 is misaligned.
//    - No mem_request is issued; IDLE -> DONE with misaligned=1 and rdata=0.
//  MISALIGN_TRAP_EN undefined:
//    - misaligned is tied to 0.
//    - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. The access proceeds normally.
// TESTING
//  1. SW wdata=0x12345678 addr=0x10, then LW addr=0x10
//     -> store: mem_address=4, mask=1111, done 2 cycles after start; load: rdata=0x12345678, done 3 cycles after start.
//  2. SB wdata=0xA5 addr=0x103
//     -> mem_mask=1000, mem_data_in=0xA5A5A5A5. Then LB -> rdata=0xFFFFFFA5; LBU -> rdata=0x000000A5.
//  3. SH wdata=0x8001 addr=0x102
//     -> mask=1100, data=0x80018001. Then LH -> rdata=0xFFFF8001; LHU -> rdata=0x00008001.
//  4. LW addr=0x11
//     -> macro defined: misaligned=1 with done and mem_request never asserted.
//     -> macro undefined: reads word 4, misaligned=0.
//  5. Load with mem_valid held low 3 cycles
//     -> busy stays 1, done arrives 6 cycles after start.
//     -> a second start during busy is ignored.
//  6. rst asserted while in WAIT
//     -> same cycle: all outputs 0 and state IDLE.
//     funct3=011 load -> err=1 with done, no mem_request.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns a byte-addressed RV32I load/store into a single word-addressed
// memory transaction and sign/zero-extends load results.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned halfword/word accesses).
module load_store_unit #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic              misaligned_o,
  output logic              mem_request_o,
  output logic              mem_we_re_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [3:0]        mem_mask_o,
  output logic [XLEN-1:0]   mem_data_in_o,
  input  logic [XLEN-1:0]   mem_data_out_i,
  input  logic              mem_valid_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              is_store_q, is_store_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic              mem_request_q, mem_request_d;
  logic              mem_we_re_q, mem_we_re_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic [XLEN-1:0]   mem_data_in_q, mem_data_in_d;

  logic              legal;
  logic              mis;
  logic [3:0]        st_mask;
  logic [XLEN-1:0]   st_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  // Bits above the word-address range alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[XLEN-1:ADDR_W+2];

  // Request decode: legality, misalignment, store lane mask and replicated data.
  always_comb begin
    legal   = 1'b0;
    mis     = 1'b0;
    st_mask = 4'b0000;
    st_data = '0;
    if (is_store_i) begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
      unique case (funct3_i[1:0])
        2'b00: begin
          st_mask = 4'b0001 << addr_i[1:0];
          st_data = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          st_mask = addr_i[1] ? 4'b1100 : 4'b0011;
          st_data = {2{wdata_i[15:0]}};
        end
        2'b10: begin
          st_mask = 4'b1111;
          st_data = wdata_i;
        end
        default: begin
          st_mask = 4'b0000;
          st_data = '0;
        end
      endcase
    end else begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
`ifdef MISALIGN_TRAP_EN
    mis = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
          ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  // Load extraction from the returned word using the latched lane and width.
  always_comb begin
    unique case (addr_lo_q)
      2'd0: ld_byte = mem_data_out_i[7:0];
      2'd1: ld_byte = mem_data_out_i[15:8];
      2'd2: ld_byte = mem_data_out_i[23:16];
      default: ld_byte = mem_data_out_i[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_data_out_i[31:16] : mem_data_out_i[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = mem_data_out_i;
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = '0;
    endcase
  end

  // Next-state logic; err/misaligned/mem_request default low so they pulse for one cycle.
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    addr_lo_d     = addr_lo_q;
    is_store_d    = is_store_q;
    rdata_d       = rdata_q;
    err_d         = 1'b0;
    mis_d         = 1'b0;
    mem_request_d = 1'b0;
    mem_we_re_d   = mem_we_re_q;
    mem_address_d = mem_address_q;
    mem_mask_d    = mem_mask_q;
    mem_data_in_d = mem_data_in_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          funct3_d      = funct3_i;
          addr_lo_d     = addr_i[1:0];
          is_store_d    = is_store_i;
          mem_we_re_d   = is_store_i;
          mem_address_d = addr_i[ADDR_W+1:2];
          mem_mask_d    = is_store_i ? st_mask : 4'b0000;
          mem_data_in_d = is_store_i ? st_data : '0;
          if (!legal) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else if (mis) begin
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            mem_request_d = 1'b1;
            state_d       = StAccess;
          end
        end
      end
      StAccess: state_d = is_store_q ? StDone : StWait;
      StWait: begin
        if (mem_valid_i) begin
          rdata_d = ld_ext;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      funct3_q      <= 3'b000;
      addr_lo_q     <= 2'b00;
      is_store_q    <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      mis_q         <= 1'b0;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_address_q <= '0;
      mem_mask_q    <= 4'b0000;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      addr_lo_q     <= addr_lo_d;
      is_store_q    <= is_store_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      mis_q         <= mis_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_address_q <= mem_address_d;
      mem_mask_q    <= mem_mask_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign misaligned_o  = mis_q;
  assign mem_request_o = mem_request_q;
  assign mem_we_re_o   = mem_we_re_q;
  assign mem_address_o = mem_address_q;
  assign mem_mask_o    = mem_mask_q;
  assign mem_data_in_o = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory transactions and completions are
// queued at issue time and compared by a monitor when the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, err_o, misaligned_o;
  logic [31:0] rdata_o;
  logic        mem_request_o, mem_we_re_o;
  logic [11:0] mem_address_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_data_in_o;
  logic [31:0] mem_data_out_i = 32'hDEADBEEF;
  logic        mem_valid_i = 1'b0;

  load_store_unit #(.ADDR_W(12), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .err_o(err_o), .misaligned_o(misaligned_o), .mem_request_o(mem_request_o),
    .mem_we_re_o(mem_we_re_o), .mem_address_o(mem_address_o), .mem_mask_o(mem_mask_o),
    .mem_data_in_o(mem_data_in_o), .mem_data_out_i(mem_data_out_i), .mem_valid_i(mem_valid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    logic        mis;
    int          lat;
  } done_t;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        we;
  } mem_t;

  done_t exp_done_q[$];
  mem_t  exp_mem_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    stall = 0;
  logic [31:0] mem_model [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: writes apply the byte mask; reads answer after 'stall' extra cycles.
  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = '0;
    forever begin
      @(negedge clk);
      if (mem_request_o) begin
        if (mem_we_re_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_mask_o[b]) mem_model[mem_address_o][8*b +: 8] = mem_data_in_o[8*b +: 8];
        end else begin
          logic [31:0] rd;
          int          n;
          rd = mem_model[mem_address_o];
          n  = stall;
          repeat (n) @(negedge clk);
          @(negedge clk);
          mem_valid_i    = 1'b1;
          mem_data_out_i = rd;
          @(negedge clk);
          mem_valid_i    = 1'b0;
          mem_data_out_i = 32'hDEADBEEF;
        end
      end
    end
  end

  // Monitor: compare every memory strobe and every completion against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_request_o) begin
          if (exp_mem_q.size() == 0) begin
            chk("unexpected_mem_request", 32'd1, 32'd0);
          end else begin
            mem_t m;
            m = exp_mem_q.pop_front();
            chk("mem_address", {20'b0, mem_address_o}, {20'b0, m.addr});
            chk("mem_mask", {28'b0, mem_mask_o}, {28'b0, m.mask});
            chk("mem_we_re", {31'b0, mem_we_re_o}, {31'b0, m.we});
            if (m.we) chk("mem_data_in", mem_data_in_o, m.data);
          end
        end
        if (done_o) begin
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            done_t d;
            d = exp_done_q.pop_front();
            chk("err", {31'b0, err_o}, {31'b0, d.err});
            chk("misaligned", {31'b0, misaligned_o}, {31'b0, d.mis});
            chk("latency", cyc - start_cyc, d.lat);
            if (d.chk_rdata) chk("rdata", rdata_o, d.rdata);
          end
        end else if (err_o || misaligned_o) begin
          chk("err_mis_without_done", {30'b0, err_o, misaligned_o}, 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    is_store_i = st;
    funct3_i   = f3;
    addr_i     = a;
    wdata_i    = wd;
    start_i    = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  task automatic push_mem(input logic [11:0] a, input logic [3:0] m, input logic [31:0] d,
                          input logic we);
    mem_t e;
    e.addr = a; e.mask = m; e.data = d; e.we = we;
    exp_mem_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] r, input logic cr, input logic e, input logic mi,
                           input int lat);
    done_t d;
    d.rdata = r; d.chk_rdata = cr; d.err = e; d.mis = mi; d.lat = lat;
    exp_done_q.push_back(d);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || busy_o) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("completion_timeout", 32'd1, 32'd0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic [31:0] d);
    push_mem(a[13:2], m, d, 1'b1);
    push_done('0, 1'b0, 1'b0, 1'b0, 2);
    issue(1'b1, f3, a, wd);
    wait_done();
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r,
                      input int n_stall);
    stall = n_stall;
    push_mem(a[13:2], 4'b0000, '0, 1'b0);
    push_done(r, 1'b1, 1'b0, 1'b0, 3 + n_stall);
    issue(1'b0, f3, a, '0);
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_done"}, {31'b0, done_o}, 32'd0);
    chk({tag, "_err_mis"}, {30'b0, err_o, misaligned_o}, 32'd0);
    chk({tag, "_req_we"}, {30'b0, mem_request_o, mem_we_re_o}, 32'd0);
    chk({tag, "_addr_mask"}, {16'b0, mem_mask_o, mem_address_o}, 32'd0);
    chk({tag, "_data_in"}, mem_data_in_o, 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Word store then load back.
    store(3'b010, 32'h10, 32'h12345678, 4'b1111, 32'h12345678);
    load(3'b010, 32'h10, 32'h12345678, 0);

    // Byte store into lane 3, then signed and unsigned byte loads.
    store(3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    load(3'b000, 32'h103, 32'hFFFFFFA5, 0);
    load(3'b100, 32'h103, 32'h000000A5, 0);

    // Halfword store into upper half (overwrites lane 3), then halfword loads.
    store(3'b001, 32'h102, 32'h00008001, 4'b1100, 32'h80018001);
    load(3'b001, 32'h102, 32'hFFFF8001, 0);
    load(3'b101, 32'h102, 32'h00008001, 0);
    load(3'b000, 32'h102, 32'h00000001, 0);
    load(3'b010, 32'h100, 32'h80010000, 0);

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    push_done(32'h0, 1'b1, 1'b0, 1'b1, 1);
    issue(1'b0, 3'b010, 32'h11, '0);
    wait_done();
`else
    load(3'b010, 32'h11, 32'h12345678, 0);
`endif

    // Upper address bits alias: 0x4010 maps to word 4.
    store(3'b010, 32'h4010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    load(3'b010, 32'h10, 32'hCAFEF00D, 0);

    // Stalled load; a start during busy must be ignored.
    stall = 3;
    push_mem(12'h004, 4'b0000, '0, 1'b0);
    push_done(32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 6);
    issue(1'b0, 3'b010, 32'h10, '0);
    is_store_i = 1'b1;
    funct3_i   = 3'b010;
    addr_i     = 32'h20;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_stall_c2", {31'b0, busy_o}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_stall", {31'b0, busy_o}, 32'd1);
    end
    wait_done();
    stall = 0;

    // Illegal funct3 on load and store.
    push_done(32'h0, 1'b1, 1'b1, 1'b0, 1);
    issue(1'b0, 3'b011, 32'h10, '0);
    wait_done();
    push_done(32'h0, 1'b1, 1'b1, 1'b0, 1);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    wait_done();

    // Refill rdata, then reset while the load sits in WAIT.
    load(3'b010, 32'h10, 32'hCAFEF00D, 0);
    stall = 20;
    push_mem(12'h004, 4'b0000, '0, 1'b0);
    push_done(32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(1'b0, 3'b010, 32'h10, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_in_wait");
    exp_done_q.delete();
    exp_mem_q.delete();
    @(negedge clk);
    rst = 1'b0;
    stall = 0;
    repeat (25) @(negedge clk);

    // Illegal load after reset, then a normal load to show recovery.
    push_done(32'h0, 1'b1, 1'b1, 1'b0, 1);
    issue(1'b0, 3'b011, 32'h10, '0);
    wait_done();
    load(3'b010, 32'h10, 32'hCAFEF00D, 0);

    repeat (3) @(negedge clk);
    chk("exp_mem_drained", exp_mem_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
